// File: rtl/if_pkg.sv
// Shared types and helpers for the I-cache refill path.
// Also used by fetch for set/tag extraction.
package if_pkg;

  localparam int B      = 8;
  localparam int BB     = 3;
  localparam int YB     = 3;
  localparam int SB     = 6;
  localparam int TB     = 64 - SB - BB - YB;
  localparam int LINE_W = 64 * B;

  localparam logic [7:0] ARLEN      = 8'(B - 1);
  localparam logic [2:0] ARSIZE_8B  = 3'd3;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RECV,
    FILL,
    HOLD
  } state_e;

  // Clear the block and byte offsets of a fetch PC.
  function automatic logic [63:0] line_addr(
    input logic [63:0] a
  );
    return a & ~64'((1 << (BB + YB)) - 1);
  endfunction

  function automatic logic [SB-1:0] set_of(
    input logic [63:0] a
  );
    return SB'(a >> (BB + YB));
  endfunction

  function automatic logic [TB-1:0] tag_of(
    input logic [63:0] a
  );
    return TB'(a >> (SB + BB + YB));
  endfunction

endpackage

// File: rtl/if_line_buf.sv
// Line assembly buffer: B words of 64 bits,
// indexed write, whole line visible at once.
module if_line_buf
  import if_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [BB-1:0]     i_idx,
  input  logic [63:0]       i_data,
  output logic [LINE_W-1:0] o_line
);

  logic [63:0] r_mem [B];

  // Store one beat; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_data;
    end
  end

  for (genvar g = 0; g < B; g++) begin : g_rd
    assign o_line[64*g +: 64] = r_mem[g];
  end

endmodule

// File: rtl/if_refill.sv
// I-cache miss handler: one AXI4 read burst per
// miss, line assembly, single-cycle fill write.
module if_refill
  import if_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              IF_miss,
  input  logic [63:0]       IF_addr,
  input  logic              lru_way,
  output logic [63:0]       m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [63:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic              fill_valid,
  output logic [SB-1:0]     fill_set,
  output logic              fill_way,
  output logic [TB-1:0]     fill_tag,
  output logic [LINE_W-1:0] fill_data,
  output logic              refill_busy,
  output logic              refill_err
);

  state_e        r_state;
  logic [63:0]   r_araddr;
  logic [SB-1:0] r_set;
  logic [TB-1:0] r_tag;
  logic          r_way;
  logic          r_arvalid;
  logic          r_rready;
  logic          r_busy;
  logic          r_fill_valid;
  logic          r_refill_err;
  logic          r_err;
  logic [BB-1:0] r_cnt;

  logic          r_bv;
  logic [BB-1:0] r_bidx;
  logic [63:0]   r_bdata;
  logic [1:0]    r_bresp;
  logic          r_blast;

  logic          w_rhs;
  logic          w_blast_exp;
  logic          w_bad;
  logic          w_err_nx;
  logic          w_last;

  assign w_rhs       = m_axi_rvalid & r_rready;
  assign w_blast_exp = (r_bidx == BB'(B - 1));
  assign w_bad       = r_bv
                     & ((r_bresp != RESP_OKAY)
                     | (r_blast != w_blast_exp));
  assign w_err_nx    = r_err | w_bad;
  assign w_last      = r_bv & w_blast_exp;

  // Register each accepted beat with its index,
  // so checks and the buffer write see a clean
  // copy one cycle after the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bv    <= 1'b0;
      r_bidx  <= '0;
      r_bresp <= '0;
      r_blast <= 1'b0;
    end else begin
      r_bv <= w_rhs;
      if (w_rhs) begin
        r_bidx  <= r_cnt;
        r_bresp <= m_axi_rresp;
        r_blast <= m_axi_rlast;
      end
    end
  end

  // Beat data is only meaningful while r_bv is set.
  always_ff @(posedge clk) begin
    if (w_rhs) begin
      r_bdata <= m_axi_rdata;
    end
  end

  // Refill sequencer with registered handshake
  // and fill strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_araddr     <= '0;
      r_set        <= '0;
      r_tag        <= '0;
      r_way        <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_busy       <= 1'b0;
      r_fill_valid <= 1'b0;
      r_refill_err <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (IF_miss) begin
            r_araddr  <= line_addr(IF_addr);
            r_set     <= set_of(IF_addr);
            r_tag     <= tag_of(IF_addr);
            r_way     <= lru_way;
            r_arvalid <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= REQ;
          end
        end
        REQ: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RECV;
          end
        end
        RECV: begin
          if (w_rhs) begin
            r_cnt <= r_cnt + BB'(1);
            if (r_cnt == BB'(B - 1)) begin
              r_rready <= 1'b0;
            end
          end
          if (r_bv) begin
            r_err <= w_err_nx;
          end
          if (w_last) begin
            r_fill_valid <= ~w_err_nx;
            r_refill_err <= w_err_nx;
            r_state      <= FILL;
          end
        end
        FILL: begin
          r_fill_valid <= 1'b0;
          r_refill_err <= 1'b0;
          r_state      <= HOLD;
        end
        HOLD: begin
          r_err   <= 1'b0;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  if_line_buf u_buf (
    .clk    (clk),
    .i_we   (r_bv),
    .i_idx  (r_bidx),
    .i_data (r_bdata),
    .o_line (fill_data)
  );

  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = ARLEN;
  assign m_axi_arsize  = ARSIZE_8B;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;
  assign fill_valid    = r_fill_valid;
  assign fill_set      = r_set;
  assign fill_way      = r_way;
  assign fill_tag      = r_tag;
  assign refill_busy   = r_busy;
  assign refill_err    = r_refill_err;

endmodule

// File: tb/tb_if_refill.sv
// Bench for if_refill: directed table, reset
// abort sequence, randomized refills vs model.
module tb_if_refill;

  logic         clk;
  logic         reset;
  logic         IF_miss;
  logic [63:0]  IF_addr;
  logic         lru_way;
  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [63:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic         fill_valid;
  logic [5:0]   fill_set;
  logic         fill_way;
  logic [51:0]  fill_tag;
  logic [511:0] fill_data;
  logic         busy;
  logic         refill_err;

  int n_vec;
  int n_err;

  typedef struct {
    logic [63:0] addr;
    bit          way;
    int          ar_wait;
    int          gap;
    int          err_beat;
    int          rlast_beat;
    bit          keep;
    bit          dmode;
    logic [63:0] exp_araddr;
    logic [5:0]  exp_set;
    logic [51:0] exp_tag;
    bit          exp_err;
  } vec_t;

  vec_t tbl[7];

  if_refill dut (
    .clk           (clk),
    .reset         (reset),
    .IF_miss       (IF_miss),
    .IF_addr       (IF_addr),
    .lru_way       (lru_way),
    .m_axi_araddr  (araddr),
    .m_axi_arlen   (arlen),
    .m_axi_arsize  (arsize),
    .m_axi_arburst (arburst),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_rdata   (rdata),
    .m_axi_rresp   (rresp),
    .m_axi_rlast   (rlast),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready),
    .fill_valid    (fill_valid),
    .fill_set      (fill_set),
    .fill_way      (fill_way),
    .fill_tag      (fill_tag),
    .fill_data     (fill_data),
    .refill_busy   (busy),
    .refill_err    (refill_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  // Reference: line/set/tag from plain arithmetic,
  // error whenever any beat is bad or rlast is
  // not exactly on the eighth beat.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    r.exp_araddr = v.addr - (v.addr % 64);
    r.exp_set    = 6'((v.addr / 64) % 64);
    r.exp_tag    = 52'(v.addr / 4096);
    r.exp_err    = (v.err_beat >= 0 && v.err_beat < 8)
                || (v.rlast_beat != 7);
    return r;
  endfunction

  task automatic run_vec(input vec_t v);
    int   cyc;
    int   h;
    int   beats;
    int   arw;
    bit   ar_done;
    bit   done;
    bit   ph;
    bit   go;
    logic [63:0] w[8];
    for (int i = 0; i < 8; i++) begin
      w[i] = v.dmode ? {$urandom, $urandom}
                     : 64'h10 + 64'(i);
    end
    IF_miss = 1'b1;
    IF_addr = v.addr;
    lru_way = v.way;
    arready = 1'b0;
    rvalid  = 1'b0;
    cyc = 0; h = 0; beats = 0;
    arw = v.ar_wait;
    ar_done = 0; done = 0; ph = 1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("ar_latency", 64'(arvalid), 64'd1);
        IF_addr = {$urandom, $urandom};
        lru_way = ~v.way;
      end
      if (!ar_done) begin
        arready = 1'b0;
        if (arvalid) begin
          chk("araddr", araddr, v.exp_araddr);
          if (arw > 0) begin
            arw--;
          end else begin
            arready = 1'b1;
            ar_done = 1;
            h = cyc;
          end
        end
      end else begin
        arready = 1'b0;
        chk("ar_dropped", 64'(arvalid), 64'd0);
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'd0;
        rdata  = '0;
        if (beats < 8) begin
          if (v.gap == 0) go = 1;
          else if (v.gap == 1) go = ph;
          else go = 1'($urandom_range(0, 1));
          ph = ~ph;
          if (go) begin
            rvalid = 1'b1;
            rdata  = w[beats];
            rresp  = (beats == v.err_beat) ? 2'd2
                                            : 2'd0;
            rlast  = (beats == v.rlast_beat);
            if (rready) beats++;
          end
        end
      end
      if (fill_valid || refill_err) done = 1;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    chk("fill_seen", 64'(done), 64'd1);
    if (done) begin
      chk("beats", 64'(beats), 64'd8);
      chk("fill_valid", 64'(fill_valid),
          64'(!v.exp_err));
      chk("refill_err", 64'(refill_err),
          64'(v.exp_err));
      if (v.gap == 0)
        chk("fill_latency", 64'(cyc - h), 64'd10);
      if (!v.exp_err) begin
        chk("fill_set", 64'(fill_set),
            64'(v.exp_set));
        chk("fill_way", 64'(fill_way), 64'(v.way));
        chk("fill_tag", 64'(fill_tag),
            64'(v.exp_tag));
        for (int i = 0; i < 8; i++)
          chk($sformatf("word%0d", i),
              fill_data[64*i +: 64], w[i]);
      end
      @(negedge clk);
      chk("hold_busy", 64'(busy), 64'd1);
      chk("hold_fill", 64'(fill_valid), 64'd0);
      chk("hold_err", 64'(refill_err), 64'd0);
      chk("hold_ar", 64'(arvalid), 64'd0);
      chk("hold_rready", 64'(rready), 64'd0);
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_ar", 64'(arvalid), 64'd0);
      if (!v.keep) begin
        IF_miss = 1'b0;
        @(negedge clk);
        chk("no_retrigger", 64'(arvalid), 64'd0);
        chk("idle2_busy", 64'(busy), 64'd0);
      end
    end
  endtask

  initial begin
    vec_t v;
    int   beats;
    n_vec = 0;
    n_err = 0;
    tbl[0] = '{64'h1234, 1'b1, 0, 0, -1, 7, 1'b0,
               1'b0, 64'h1200, 6'h08, 52'h1, 1'b0};
    tbl[1] = '{64'h8000_0000_0000_ABC8, 1'b0, 5, 1,
               -1, 7, 1'b0, 1'b1,
               64'h8000_0000_0000_ABC0, 6'h2F,
               52'h8_0000_0000_000A, 1'b0};
    tbl[2] = '{64'h40, 1'b1, 0, 0, 3, 7, 1'b1, 1'b1,
               64'h40, 6'h01, 52'h0, 1'b1};
    tbl[3] = '{64'h40, 1'b1, 0, 0, -1, 7, 1'b0,
               1'b1, 64'h40, 6'h01, 52'h0, 1'b0};
    tbl[4] = '{64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 0, 0,
               -1, 5, 1'b0, 1'b1,
               64'hFFFF_FFFF_FFFF_FFC0, 6'h3F,
               52'hF_FFFF_FFFF_FFFF, 1'b1};
    tbl[5] = '{64'h7FC0, 1'b1, 2, 2, -1, 7, 1'b0,
               1'b1, 64'h7FC0, 6'h3F, 52'h7, 1'b0};
    tbl[6] = '{64'h0000_1234_5678_9ABC, 1'b0, 1, 0,
               -1, -1, 1'b0, 1'b1,
               64'h0000_1234_5678_9A80, 6'h2A,
               52'h0_0001_2345_6789, 1'b1};

    reset = 1'b1; IF_miss = 1'b0; IF_addr = '0;
    lru_way = 1'b0; arready = 1'b0; rdata = '0;
    rresp = 2'd0; rlast = 1'b0; rvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_fill", 64'(fill_valid), 64'd0);
    chk("rst_err", 64'(refill_err), 64'd0);
    chk("rst_araddr", araddr, 64'd0);
    chk("rst_set", 64'(fill_set), 64'd0);
    chk("rst_way", 64'(fill_way), 64'd0);
    chk("rst_tag", 64'(fill_tag), 64'd0);
    chk("arlen", 64'(arlen), 64'd7);
    chk("arsize", 64'(arsize), 64'd3);
    chk("arburst", 64'(arburst), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Abort in the middle of a burst.
    IF_miss = 1'b1; IF_addr = 64'h3000;
    lru_way = 1'b0; arready = 1'b1; beats = 0;
    for (int c = 0; c < 50 && beats < 4; c++) begin
      @(negedge clk);
      rvalid = 1'b0;
      if (rready) begin
        rvalid = 1'b1;
        rdata  = 64'(beats);
        rlast  = 1'b0;
        rresp  = 2'd0;
        beats++;
      end
    end
    chk("rst_pre_beats", 64'(beats), 64'd4);
    @(negedge clk);
    reset = 1'b1; rvalid = 1'b0; arready = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rready", 64'(rready), 64'd0);
    chk("abort_fill", 64'(fill_valid), 64'd0);
    chk("abort_ar", 64'(arvalid), 64'd0);
    reset = 1'b0; IF_miss = 1'b0;
    @(negedge clk);
    chk("abort_idle", 64'(busy), 64'd0);
    v = '{64'h3008, 1'b1, 0, 0, -1, 7, 1'b0, 1'b1,
          '0, '0, '0, 1'b0};
    run_vec(model(v));

    for (int i = 0; i < 25; i++) begin
      v.addr     = {$urandom, $urandom};
      v.way      = 1'($urandom_range(0, 1));
      v.ar_wait  = $urandom_range(0, 3);
      v.gap      = $urandom_range(0, 2);
      v.err_beat = ($urandom_range(0, 9) < 7) ? -1
                 : $urandom_range(0, 7);
      v.rlast_beat = ($urandom_range(0, 9) < 7) ? 7
                   : $urandom_range(0, 8) - 1;
      v.keep     = 1'b0;
      v.dmode    = 1'b1;
      run_vec(model(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
